prom_mb7112_reader: RTL and testbench

- Synchronous read initiator for the MB7112 32x8 bipolar PROM model and other GENERIC_PROM-based parts.
- Drives the PROM's active-low enable and address, waits a fixed number of clocks to cover access time, captures Q, then holds the enable off for a recovery period.
- Serves two clients: single-byte reads over a REQ/ACK handshake, and a bulk DUMP that copies every PROM location into a shadow RAM through a write port.
- Sits between System86 clocked logic (palette/priority shadow loaders) and the asynchronous PROM model.

---
 rtl/prom_mb7112_reader.sv | 194 +++++++++++++++++++
 tb/tb_prom_mb7112_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prom_mb7112_reader.sv
// Synchronous read initiator for MB7112-style asynchronous PROMs.
// Drives the PROM enable and address, waits out the access time, captures Q,
// then holds the enable off for a recovery period. It serves single-byte
// REQ/ACK reads and a bulk DUMP that streams every location to a shadow RAM.
module prom_mb7112_reader #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 8,
    parameter int WAIT_CYCLES    = 4,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic                  REQ,
    input  logic [ADDR_WIDTH-1:0] REQ_A,
    output logic                  ACK,
    output logic [DATA_WIDTH-1:0] DOUT,
    input  logic                  DUMP,
    output logic                  BUSY,
    output logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_A,
    output logic [DATA_WIDTH-1:0] WR_D,
    output logic                  DONE,
    output logic                  PROM_nE,
    output logic [ADDR_WIDTH-1:0] PROM_A,
    input  logic [DATA_WIDTH-1:0] PROM_Q
);

    // Timing parameters must fit the 4-bit wait and release counters.
    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 ||
            RELEASE_CYCLES < 0 || RELEASE_CYCLES > 15) begin : g_param_err
            initial begin
                $display("prom_mb7112_reader: WAIT_CYCLES must be 1..15 and RELEASE_CYCLES 0..15");
                $finish;
            end
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RELEASE
    } state_t;

    // Wait counter runs WAIT_CYCLES-1 .. 0; capture happens on the zero edge.
    localparam logic [3:0] WAIT_LOAD     = 4'(WAIT_CYCLES - 1);
    // A single read returns to IDLE on the release expiry edge and the next
    // accept costs one more edge. A dump spends that extra edge in RELEASE
    // instead, so both paths keep the same WAIT+RELEASE+1 period.
    localparam logic [3:0] REL_LOAD_READ = (RELEASE_CYCLES > 0) ? 4'(RELEASE_CYCLES - 1) : 4'd0;
    localparam logic [3:0] REL_LOAD_DUMP = 4'(RELEASE_CYCLES);
    localparam bit         HAS_RELEASE   = (RELEASE_CYCLES > 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = '1;

    state_t                r_state;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            r_rel_cnt;
    logic                  r_dump;
    logic                  r_last;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_busy;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_a;
    logic [DATA_WIDTH-1:0] r_wr_d;
    logic                  r_done;
    logic                  r_prom_ne;
    logic [ADDR_WIDTH-1:0] r_prom_a;

    logic w_wait_done;
    logic w_rel_done;
    logic w_at_last;

    assign w_wait_done = (r_wait_cnt == 4'd0);
    assign w_rel_done  = (r_rel_cnt == 4'd0);
    assign w_at_last   = (r_prom_a == LAST_A);

    // Access sequencer: accept, wait for access time, capture, recover.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_rel_cnt  <= 4'd0;
            r_dump     <= 1'b0;
            r_last     <= 1'b0;
            r_ack      <= 1'b0;
            r_dout     <= '0;
            r_busy     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_a     <= '0;
            r_wr_d     <= '0;
            r_done     <= 1'b0;
            r_prom_ne  <= 1'b1;
            r_prom_a   <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_ack   <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (DUMP) begin
                        // Dump wins over a simultaneous REQ; the REQ is dropped.
                        r_dump     <= 1'b1;
                        r_last     <= 1'b0;
                        r_prom_a   <= '0;
                        r_prom_ne  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_wait_cnt <= WAIT_LOAD;
                        r_state    <= S_ACCESS;
                    end else if (REQ) begin
                        r_dump     <= 1'b0;
                        r_prom_a   <= REQ_A;
                        r_prom_ne  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_wait_cnt <= WAIT_LOAD;
                        r_state    <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (!w_wait_done) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else begin
                        // Capture edge: PROM_Q is only looked at here.
                        r_prom_ne <= 1'b1;
                        if (r_dump) begin
                            r_wr_d    <= PROM_Q;
                            r_wr_a    <= r_prom_a;
                            r_wr_en   <= 1'b1;
                            r_done    <= w_at_last;
                            r_last    <= w_at_last;
                            r_rel_cnt <= REL_LOAD_DUMP;
                            r_state   <= S_RELEASE;
                            if (!HAS_RELEASE) begin
                                r_prom_a <= r_prom_a + 1'b1;
                            end
                        end else begin
                            r_dout <= PROM_Q;
                            r_ack  <= 1'b1;
                            if (HAS_RELEASE) begin
                                r_rel_cnt <= REL_LOAD_READ;
                                r_state   <= S_RELEASE;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end

                S_RELEASE: begin
                    if (!w_rel_done) begin
                        r_rel_cnt <= r_rel_cnt - 4'd1;
                    end else begin
                        if (r_dump && HAS_RELEASE) begin
                            r_prom_a <= r_prom_a + 1'b1;
                        end
                        if (r_dump && !r_last) begin
                            // Next dump location: behaves exactly like an accept.
                            r_prom_ne  <= 1'b0;
                            r_wait_cnt <= WAIT_LOAD;
                            r_state    <= S_ACCESS;
                        end else begin
                            r_dump  <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_prom_ne <= 1'b1;
                    r_busy    <= 1'b0;
                    r_dump    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign ACK     = r_ack;
    assign DOUT    = r_dout;
    assign BUSY    = r_busy;
    assign WR_EN   = r_wr_en;
    assign WR_A    = r_wr_a;
    assign WR_D    = r_wr_d;
    assign DONE    = r_done;
    assign PROM_nE = r_prom_ne;
    assign PROM_A  = r_prom_a;

endmodule

// File: tb/tb_prom_mb7112_reader.sv
// Bench for prom_mb7112_reader: default timing instance (index 0) and a
// WAIT_CYCLES=1 / RELEASE_CYCLES=0 instance (index 1), each with a PROM model
// holding Q[a] = a ^ 8'hA5 that returns junk if read before its access time.
module tb_prom_mb7112_reader;

    localparam int W0 = 4;
    localparam int R0 = 2;
    localparam int W1 = 1;
    localparam int R1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst[2];
    logic       req[2];
    logic       dump[2];
    logic [4:0] req_a[2];
    logic       ack[2];
    logic       busy[2];
    logic       wr_en[2];
    logic       done[2];
    logic       prom_ne[2];
    logic [7:0] dout[2];
    logic [7:0] wr_d[2];
    logic [7:0] prom_q[2];
    logic [4:0] wr_a[2];
    logic [4:0] prom_a[2];
    int         lowcnt[2];

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [4:0] a;
        logic [7:0] q;
    } rd_vec_t;
    rd_vec_t vecs[6];

    prom_mb7112_reader #(
        .ADDR_WIDTH(5), .DATA_WIDTH(8), .WAIT_CYCLES(W0), .RELEASE_CYCLES(R0)
    ) dut0 (
        .CLK(clk), .nRESET(nrst[0]), .REQ(req[0]), .REQ_A(req_a[0]),
        .ACK(ack[0]), .DOUT(dout[0]), .DUMP(dump[0]), .BUSY(busy[0]),
        .WR_EN(wr_en[0]), .WR_A(wr_a[0]), .WR_D(wr_d[0]), .DONE(done[0]),
        .PROM_nE(prom_ne[0]), .PROM_A(prom_a[0]), .PROM_Q(prom_q[0])
    );

    prom_mb7112_reader #(
        .ADDR_WIDTH(5), .DATA_WIDTH(8), .WAIT_CYCLES(W1), .RELEASE_CYCLES(R1)
    ) dut1 (
        .CLK(clk), .nRESET(nrst[1]), .REQ(req[1]), .REQ_A(req_a[1]),
        .ACK(ack[1]), .DOUT(dout[1]), .DUMP(dump[1]), .BUSY(busy[1]),
        .WR_EN(wr_en[1]), .WR_A(wr_a[1]), .WR_D(wr_d[1]), .DONE(done[1]),
        .PROM_nE(prom_ne[1]), .PROM_A(prom_a[1]), .PROM_Q(prom_q[1])
    );

    // PROM models: count edges with enable low; data valid once access time is met.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            lowcnt[d] <= prom_ne[d] ? 0 : lowcnt[d] + 1;
        end
    end

    assign prom_q[0] = (!prom_ne[0] && lowcnt[0] >= W0 - 1) ? ({3'b000, prom_a[0]} ^ 8'hA5) : 8'hEE;
    assign prom_q[1] = (!prom_ne[1] && lowcnt[1] >= W1 - 1) ? ({3'b000, prom_a[1]} ^ 8'hA5) : 8'hEE;

    function automatic int wc(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic int rc(input int d);
        return (d == 0) ? R0 : R1;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Single read: latency, ACK width, captured data and enable-low duration.
    task automatic do_read(input int d, input logic [4:0] a, input logic [7:0] q, input string nm);
        int per  = wc(d) + rc(d) + 1;
        int lat  = -1;
        int acks = 0;
        int nlow = 0;
        logic [7:0] got = 8'h00;
        req[d]   = 1'b1;
        req_a[d] = a;
        tick();
        req[d] = 1'b0;
        for (int i = 0; i < per + 2; i++) begin
            if (!prom_ne[d]) nlow++;
            if (ack[d]) begin
                acks++;
                if (lat < 0) begin
                    lat = i;
                    got = dout[d];
                end
            end
            tick();
        end
        chk({nm, " ack latency"}, lat, wc(d));
        chk({nm, " ack count"}, acks, 1);
        chk({nm, " dout"}, {24'h0, got}, {24'h0, q});
        chk({nm, " nE low cycles"}, nlow, wc(d));
    endtask

    // REQ held high across two reads: spacing, data, release gap, address hold.
    task automatic b2b(input int d, input logic [4:0] a1, input logic [7:0] q1,
                       input logic [4:0] a2, input logic [7:0] q2, input string nm);
        int per      = wc(d) + rc(d) + 1;
        int acks     = 0;
        int nhigh    = 0;
        int unstable = 0;
        int ai[2];
        logic [7:0] dq[2];
        ai[0] = 0; ai[1] = 0; dq[0] = 8'h00; dq[1] = 8'h00;
        req[d]   = 1'b1;
        req_a[d] = a1;
        tick();
        req_a[d] = a2;
        for (int i = 0; i < 2 * per; i++) begin
            if (ack[d]) begin
                if (acks < 2) begin
                    ai[acks] = i;
                    dq[acks] = dout[d];
                end
                acks++;
            end
            if (i < per && prom_ne[d]) begin
                nhigh++;
                if (prom_a[d] !== a1) unstable++;
            end
            if (i == per) req[d] = 1'b0;
            tick();
        end
        chk({nm, " ack count"}, acks, 2);
        chk({nm, " ack spacing"}, ai[1] - ai[0], per);
        chk({nm, " dout first"}, {24'h0, dq[0]}, {24'h0, q1});
        chk({nm, " dout second"}, {24'h0, dq[1]}, {24'h0, q2});
        chk({nm, " nE high gap"}, nhigh, rc(d) + 1);
        chk({nm, " addr unstable"}, unstable, 0);
        chk({nm, " idle after"}, {31'h0, busy[d]}, 32'h0);
    endtask

    // Full dump; optionally with a simultaneous REQ and REQ/DUMP noise while busy.
    task automatic run_dump(input int d, input string nm, input bit noisy);
        int per      = wc(d) + rc(d) + 1;
        int n        = 0;
        int bad_a    = 0;
        int bad_d    = 0;
        int bad_gap  = 0;
        int first    = -1;
        int last     = -1;
        int done_n   = 0;
        int done_i   = -1;
        int fall     = -1;
        int busy_cnt = 0;
        int acks     = 0;
        logic [7:0] dout0;
        dout0    = dout[d];
        dump[d]  = 1'b1;
        req[d]   = noisy;
        req_a[d] = 5'h07;
        tick();
        dump[d] = 1'b0;
        req[d]  = 1'b0;
        for (int i = 0; i < per * 32 + 16; i++) begin
            if (wr_en[d]) begin
                if (wr_a[d] !== 5'(n)) bad_a++;
                if (wr_d[d] !== (8'(n) ^ 8'hA5)) bad_d++;
                if (last >= 0 && i - last != per) bad_gap++;
                if (first < 0) first = i;
                last = i;
                n++;
            end
            if (done[d]) begin
                done_n++;
                done_i = i;
            end
            if (ack[d]) acks++;
            if (busy[d]) busy_cnt++;
            if (fall < 0 && !busy[d]) fall = i;
            if (noisy) begin
                req[d]  = (i % 20 >= 5) && (i % 20 < 8) && (i < per * 32 - 10);
                dump[d] = (i == 30);
            end
            tick();
        end
        chk({nm, " strobes"}, n, 32);
        chk({nm, " first strobe"}, first, wc(d));
        chk({nm, " addr errors"}, bad_a, 0);
        chk({nm, " data errors"}, bad_d, 0);
        chk({nm, " spacing errors"}, bad_gap, 0);
        chk({nm, " done count"}, done_n, 1);
        chk({nm, " done on last"}, done_i, last);
        chk({nm, " busy fall"}, fall - done_i, rc(d) + 1);
        chk({nm, " busy cycles"}, busy_cnt, per * 32);
        if (noisy) begin
            chk({nm, " acks"}, acks, 0);
            chk({nm, " dout kept"}, {24'h0, dout[d]}, {24'h0, dout0});
        end
    endtask

    initial begin
        int n;
        int cnt;
        bit reached;

        vecs[0] = '{5'h03, 8'hA6};
        vecs[1] = '{5'h0A, 8'hAF};
        vecs[2] = '{5'h15, 8'hB0};
        vecs[3] = '{5'h1C, 8'hB9};
        vecs[4] = '{5'h1F, 8'hBA};
        vecs[5] = '{5'h00, 8'hA5};

        for (int d = 0; d < 2; d++) begin
            nrst[d]  = 1'b0;
            req[d]   = 1'b0;
            dump[d]  = 1'b0;
            req_a[d] = 5'h00;
        end
        req[0]   = 1'b1;
        req_a[0] = 5'h03;

        // Reset held 3 clocks with REQ high: everything sits at reset values.
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("reset state dut%0d cyc%0d", d, c),
                    {1'b0, ack[d], busy[d], wr_en[d], done[d], prom_ne[d],
                     prom_a[d], dout[d], wr_a[d], wr_d[d]},
                    32'h0400_0000);
            end
        end

        // Release reset; the first vector (0x03) is the read accepted right away.
        nrst[0] = 1'b1;
        for (int v = 0; v < 6; v++) begin
            do_read(0, vecs[v].a, vecs[v].q, $sformatf("read %02h", vecs[v].a));
        end

        b2b(0, 5'h1F, 8'hBA, 5'h00, 8'hA5, "b2b");

        run_dump(0, "dump", 1'b0);
        run_dump(0, "dump+req", 1'b1);

        // Reset asserted during the 10th write strobe of a dump.
        dump[0] = 1'b1;
        tick();
        dump[0] = 1'b0;
        n = 0;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (wr_en[0]) n++;
            if (n == 10) reached = 1'b1;
            else tick();
        end
        chk("midreset reached 10th strobe", {31'h0, reached}, 32'h1);
        chk("midreset addr before", {27'h0, prom_a[0]}, 32'h9);
        nrst[0] = 1'b0;
        tick();
        chk("midreset nE", {31'h0, prom_ne[0]}, 32'h1);
        chk("midreset busy", {31'h0, busy[0]}, 32'h0);
        chk("midreset addr", {27'h0, prom_a[0]}, 32'h0);
        nrst[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_en[0] || done[0]) cnt++;
            tick();
        end
        chk("midreset stray strobes", cnt, 0);
        run_dump(0, "dump restart", 1'b0);

        // Fast corner instance: WAIT_CYCLES=1, RELEASE_CYCLES=0.
        nrst[1] = 1'b1;
        tick();
        do_read(1, 5'h03, 8'hA6, "fast read 03");
        do_read(1, 5'h1F, 8'hBA, "fast read 1f");
        b2b(1, 5'h0A, 8'hAF, 5'h15, 8'hB0, "fast b2b");
        run_dump(1, "fast dump", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
